// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch front end: single-outstanding imem fetch,
// redirect squashing (including an in-flight response) and a stretched pipe flush.
// Optional PC_FETCH_PERF_EN adds saturating redirect/discard event counters.
module pc_fetch_unit #(
    parameter int          ADDR_W       = 32,
    parameter int          INSTR_W      = 32,
    parameter int          PC_STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pc_select_i,
    input  logic               clear_pipes_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               stall_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_valid_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
`ifdef PC_FETCH_PERF_EN
    output logic [15:0]        redirect_cnt_o,
    output logic [15:0]        discard_cnt_o,
`endif
    output logic               flush_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [FCW-1:0]    flush_cnt;
    logic              can_issue;
    logic              consume;
    logic              discard;

    // A request is only launched when the output slot will be free by the time
    // the response can arrive, so the response never has to be buffered.
    assign can_issue   = !instr_valid_o || !stall_i;
    assign consume     = instr_valid_o && !stall_i;
    assign imem_req_o  = !rst_i && (state == IDLE) && !pc_select_i && can_issue;
    assign imem_addr_o = pc;
    assign flush_o     = (flush_cnt != '0);
    assign discard     = imem_valid_i && ((state == DRAIN) || ((state == WAIT) && pc_select_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_select_i) begin
                        pc <= branch_target_i;
                    end else if (can_issue) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid_i) begin
                        if (pc_select_i) begin
                            pc <= branch_target_i;
                        end else begin
                            pc <= pc + ADDR_W'(PC_STEP);
                        end
                        state <= IDLE;
                    end else if (pc_select_i) begin
                        pc    <= branch_target_i;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The response still owed by memory belongs to the old path.
                    if (pc_select_i) begin
                        pc <= branch_target_i;
                    end
                    if (imem_valid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A redirect empties the IF/ID slot even when decode is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
        end else if (pc_select_i) begin
            instr_valid_o <= 1'b0;
        end else if ((state == WAIT) && imem_valid_i) begin
            instr_valid_o <= 1'b1;
            instr_o       <= imem_data_i;
            instr_pc_o    <= pc;
        end else if (consume) begin
            instr_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_cnt <= '0;
        end else if (clear_pipes_i) begin
            flush_cnt <= FCW'(FLUSH_CYCLES);
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

`ifdef PC_FETCH_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirect_cnt_o <= '0;
            discard_cnt_o  <= '0;
        end else begin
            if (pc_select_i && (redirect_cnt_o != 16'hFFFF)) begin
                redirect_cnt_o <= redirect_cnt_o + 16'd1;
            end
            if (discard && (discard_cnt_o != 16'hFFFF)) begin
                discard_cnt_o <= discard_cnt_o + 16'd1;
            end
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a behavioural memory with random latency
// drives responses, and an abstract fetch model predicts every output.
module tb_pc_fetch_unit;

    localparam int ADDR_W       = 32;
    localparam int INSTR_W      = 32;
    localparam int FLUSH_CYCLES = 2;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               pc_select_i;
    logic               clear_pipes_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic               stall_i;
    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_valid_i;
    logic [INSTR_W-1:0] imem_data_i;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc_o;
    logic               instr_valid_o;
    logic               flush_o;
`ifdef PC_FETCH_PERF_EN
    logic [15:0]        redirect_cnt_o;
    logic [15:0]        discard_cnt_o;
`endif

    pc_fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_STEP(4),
        .RESET_PC(32'h0), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pc_select_i(pc_select_i), .clear_pipes_i(clear_pipes_i),
        .branch_target_i(branch_target_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
`ifdef PC_FETCH_PERF_EN
        .redirect_cnt_o(redirect_cnt_o), .discard_cnt_o(discard_cnt_o),
`endif
        .flush_o(flush_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Abstract model: PC, whether a fetch is owed by memory, whether that
    // fetch has been made wrong-path, and the IF/ID slot contents.
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_stale;
    bit          m_have;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    int          m_flush_left;
    int          m_redirects;
    int          m_discards;

    bit          mem_pending;
    int          mem_wait;
    logic [31:0] mem_addr;
    bit          mem_late;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_busy = 0; m_stale = 0; m_have = 0;
        m_instr = 32'h0; m_ipc = 32'h0; m_flush_left = 0;
        m_redirects = 0; m_discards = 0;
    endtask

    task automatic check_registered();
        check_output("valid", {63'd0, instr_valid_o}, {63'd0, m_have});
        check_output("instr", {32'd0, instr_o}, {32'd0, m_instr});
        check_output("instr_pc", {32'd0, instr_pc_o}, {32'd0, m_ipc});
        check_output("flush", {63'd0, flush_o}, {63'd0, m_flush_left != 0});
`ifdef PC_FETCH_PERF_EN
        check_output("redirect_cnt", {48'd0, redirect_cnt_o}, 64'(m_redirects > 65535 ? 65535 : m_redirects));
        check_output("discard_cnt", {48'd0, discard_cnt_o}, 64'(m_discards > 65535 ? 65535 : m_discards));
`endif
    endtask

    // One clock cycle, entered just after a falling edge.
    task automatic apply_stimulus(input bit after_reset);
        logic        psel, stall, clr, ivalid, exp_req;
        logic [31:0] target, idata;
        check_registered();
        psel  = ($urandom_range(0, 7) == 0);
        stall = ($urandom_range(0, 2) == 0);
        clr   = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        else                           target = $urandom & 32'hFFFF_FFFC;
        if (after_reset) begin
            psel = 0; stall = 0;
        end
        ivalid = 0;
        idata  = $urandom;
        if (after_reset && mem_late) begin
            ivalid = 1; idata = 32'hDEAD_BEEF; mem_late = 0;
        end else if (mem_pending) begin
            mem_wait--;
            if (mem_wait == 0) begin
                ivalid = 1; idata = mem_word(mem_addr); mem_pending = 0;
            end
        end
        pc_select_i = psel; stall_i = stall; clear_pipes_i = clr;
        branch_target_i = target; imem_valid_i = ivalid; imem_data_i = idata;
        #1;
        exp_req = !m_busy && !psel && (!m_have || !stall);
        check_output("req", {63'd0, imem_req_o}, {63'd0, exp_req});
        if (exp_req) check_output("addr", {32'd0, imem_addr_o}, {32'd0, m_pc});
        if (imem_req_o) begin
            mem_pending = 1; mem_wait = $urandom_range(1, 4); mem_addr = imem_addr_o;
        end
        if (psel) m_redirects++;
        if (m_busy && ivalid && (psel || m_stale)) m_discards++;
        if (psel) begin
            m_pc = target; m_have = 0;
            if (m_busy) begin
                if (ivalid) begin m_busy = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else begin
            if (m_busy && ivalid) begin
                if (!m_stale) begin
                    m_have = 1; m_ipc = m_pc; m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4;
                end
                m_busy = 0; m_stale = 0;
            end else if (m_have && !stall) begin
                m_have = 0;
            end
            if (exp_req) m_busy = 1;
        end
        if (clr) m_flush_left = FLUSH_CYCLES;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    task automatic do_reset();
        rst_i = 1; pc_select_i = 0; clear_pipes_i = 0; stall_i = 0; imem_valid_i = 0;
        #1;
        model_reset();
        check_registered();
        check_output("req_in_reset", {63'd0, imem_req_o}, 64'd0);
        mem_late = mem_pending;
        mem_pending = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        apply_stimulus(1);
    endtask

    initial begin
        rst_i = 1; pc_select_i = 0; clear_pipes_i = 0; stall_i = 0;
        branch_target_i = '0; imem_valid_i = 0; imem_data_i = '0;
        mem_pending = 0; mem_wait = 0; mem_addr = '0; mem_late = 0;
        model_reset();
        @(negedge clk_i);
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 800; i++) begin
                @(negedge clk_i);
                apply_stimulus(0);
            end
            for (int k = 0; k < 20 && !m_busy; k++) begin
                @(negedge clk_i);
                apply_stimulus(0);
            end
            check_output("reach_wait", {63'd0, m_busy}, 64'd1);
            @(negedge clk_i);
            do_reset();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk_i);
                apply_stimulus(0);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
